// File: rtl/sd_spi_pkg.sv
// Shared constants for the SD-card SPI master: register offsets, FSM encoding, STATUS bit positions.
package sd_spi_pkg;
    localparam int MAX_BITS = 32;
    localparam int NBITS_W  = 6;

    localparam logic [7:0] REG_TXDATA = 8'h00;
    localparam logic [7:0] REG_CTRL   = 8'h04;
    localparam logic [7:0] REG_STATUS = 8'h08;
    localparam logic [7:0] REG_DIV    = 8'h0C;
    localparam logic [7:0] REG_CS     = 8'h10;
    localparam logic [7:0] REG_IRQEN  = 8'h14;

    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2,
        ST_FIN  = 2'd3
    } state_t;
endpackage

// File: rtl/sd_spi_ctrl_if.sv
// APB2 slave bundle for sd_spi_ctrl; pready is always 1 (no wait states).
interface sd_spi_ctrl_if #(parameter int ADDR_W = 8);
    logic [ADDR_W-1:0] paddr;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [31:0]       pwdata;
    logic [31:0]       prdata;
    logic              pready;

    modport master (output paddr, psel, penable, pwrite, pwdata, input prdata, pready);
    modport slave  (input paddr, psel, penable, pwrite, pwdata, output prdata, pready);
endinterface

// File: rtl/sd_spi_clkdiv.sv
// SCK half-period divider: counts 0..div while enabled and pulses tc on the terminal count.
module sd_spi_clkdiv (
    input  logic       clk,
    input  logic       resetb,
    input  logic       en,
    input  logic       clr,
    input  logic [7:0] div,
    output logic       tc
);
    logic [7:0] cnt;

    assign tc = en && (cnt == div);

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            cnt <= '0;
        end else if (clr || !en || tc) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 8'd1;
        end
    end
endmodule

// File: rtl/sd_spi_ctrl.sv
// APB2 SPI master for the SD card: mode-0 SCK, MSB-first, 1..32 bit words, software-owned CS/OE.
// Optional transfer-done interrupt and IRQEN register at 0x14 when SD_SPI_IRQ_EN is defined.
//
// state | meaning
// IDLE  | waiting for a valid CTRL write
// LOW   | SCK low half-period, MOSI holds current bit
// HIGH  | SCK high half-period, MISO already sampled
// FIN   | one cycle: publish RXDATA, set done
module sd_spi_ctrl #(
    parameter int         ADDR_W    = 8,
    parameter logic [7:0] DIV_RESET = 8'd124,
    parameter int         MAX_BITS  = 32
) (
    input  logic         clk,
    input  logic         resetb,
    sd_spi_ctrl_if.slave apb,
    output logic         spi_sck,
    output logic         spi_mosi,
    input  logic         spi_miso,
    output logic         spi_cs_n,
    output logic         spi_oe,
    output logic         irq
);
    import sd_spi_pkg::*;

    state_t               state, state_nxt;
    logic [MAX_BITS-1:0]  txdata, tx_shift, rx_shift, rxdata, tx_aligned;
    logic [7:0]           div_val;
    logic [1:0]           cs_reg;
    logic [NBITS_W-1:0]   nbits_last, bitcnt, wr_nbits;
    logic                 done, busy, tc, start, nbits_ok;
    logic                 wr_en, rd_en, done_clr;
    logic                 wr_txdata, wr_ctrl, wr_status, wr_div, wr_cs;
    logic [31:0]          rd_data;

    assign wr_en     = apb.psel && apb.penable && apb.pwrite;
    assign rd_en     = apb.psel && apb.penable && !apb.pwrite;
    assign wr_txdata = wr_en && (apb.paddr == ADDR_W'(REG_TXDATA));
    assign wr_ctrl   = wr_en && (apb.paddr == ADDR_W'(REG_CTRL));
    assign wr_status = wr_en && (apb.paddr == ADDR_W'(REG_STATUS));
    assign wr_div    = wr_en && (apb.paddr == ADDR_W'(REG_DIV));
    assign wr_cs     = wr_en && (apb.paddr == ADDR_W'(REG_CS));

    assign wr_nbits   = apb.pwdata[NBITS_W-1:0];
    assign nbits_ok   = (wr_nbits != '0) && (wr_nbits <= NBITS_W'(MAX_BITS));
    assign busy       = (state != ST_IDLE);
    assign start      = wr_ctrl && nbits_ok && !busy;
    assign done_clr   = wr_status && apb.pwdata[STAT_DONE];
    // Left-align the word so MOSI always comes from the top bit of the shifter.
    assign tx_aligned = txdata << (NBITS_W'(MAX_BITS) - wr_nbits);

    sd_spi_clkdiv u_clkdiv (
        .clk    (clk),
        .resetb (resetb),
        .en     (busy),
        .clr    (start),
        .div    (div_val),
        .tc     (tc)
    );

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_LOW;
            ST_LOW:  if (tc) state_nxt = ST_HIGH;
            ST_HIGH: if (tc) state_nxt = (bitcnt == NBITS_W'(1)) ? ST_FIN : ST_LOW;
            ST_FIN:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            txdata     <= '0;
            div_val    <= DIV_RESET;
            cs_reg     <= '0;
            nbits_last <= '0;
            bitcnt     <= '0;
            tx_shift   <= '0;
            rx_shift   <= '0;
            rxdata     <= '0;
            spi_sck    <= 1'b0;
            spi_mosi   <= 1'b1;
            done       <= 1'b0;
        end else begin
            if (wr_txdata && !busy) txdata <= apb.pwdata[MAX_BITS-1:0];
            if (wr_div && !busy)    div_val <= apb.pwdata[7:0];
            if (wr_cs)              cs_reg <= apb.pwdata[1:0];

            if (start) begin
                nbits_last <= wr_nbits;
                bitcnt     <= wr_nbits;
                tx_shift   <= tx_aligned;
                rx_shift   <= '0;
                spi_mosi   <= tx_aligned[MAX_BITS-1];
            end

            case (state)
                ST_LOW: begin
                    if (tc) begin
                        spi_sck  <= 1'b1;
                        rx_shift <= {rx_shift[MAX_BITS-2:0], spi_miso};
                    end
                end
                ST_HIGH: begin
                    if (tc) begin
                        spi_sck <= 1'b0;
                        bitcnt  <= bitcnt - NBITS_W'(1);
                        if (bitcnt != NBITS_W'(1)) begin
                            tx_shift <= tx_shift << 1;
                            spi_mosi <= tx_shift[MAX_BITS-2];
                        end
                    end
                end
                ST_FIN: begin
                    rxdata   <= rx_shift;
                    spi_mosi <= 1'b1;
                end
                default: ;
            endcase

            // A completion in the same cycle as a W1C keeps done set.
            if (state == ST_FIN) done <= 1'b1;
            else if (done_clr)   done <= 1'b0;
        end
    end

    assign spi_cs_n = ~cs_reg[0];
    assign spi_oe   = cs_reg[1];

`ifdef SD_SPI_IRQ_EN
    logic irqen, irq_q;

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            irqen <= 1'b0;
            irq_q <= 1'b0;
        end else begin
            if (wr_en && (apb.paddr == ADDR_W'(REG_IRQEN))) irqen <= apb.pwdata[0];
            irq_q <= done && irqen && !(done_clr && state != ST_FIN);
        end
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        rd_data = '1;
        case (apb.paddr)
            ADDR_W'(REG_TXDATA): rd_data = 32'(rxdata);
            ADDR_W'(REG_CTRL):   rd_data = 32'(nbits_last);
            ADDR_W'(REG_STATUS): rd_data = {30'd0, done, busy};
            ADDR_W'(REG_DIV):    rd_data = {24'd0, div_val};
            ADDR_W'(REG_CS):     rd_data = {30'd0, cs_reg};
`ifdef SD_SPI_IRQ_EN
            ADDR_W'(REG_IRQEN):  rd_data = {31'd0, irqen};
`endif
            default:             rd_data = '1;
        endcase
    end

    assign apb.prdata = rd_en ? rd_data : 32'd0;
    assign apb.pready = 1'b1;
endmodule

// File: tb/tb_sd_spi_ctrl.sv
// Self-checking bench for sd_spi_ctrl: randomized transfers against a bit-level reference model.
module tb_sd_spi_ctrl;
    logic clk = 1'b0;
    logic resetb = 1'b0;
    always #5 clk = ~clk;

    sd_spi_ctrl_if #(.ADDR_W(8)) apb();

    logic spi_sck, spi_mosi, spi_miso, spi_cs_n, spi_oe, irq;
    logic loopback = 1'b0;
    logic miso_drv = 1'b0;
    assign spi_miso = loopback ? spi_mosi : miso_drv;

    sd_spi_ctrl #(.ADDR_W(8), .DIV_RESET(8'd124), .MAX_BITS(32)) dut (
        .clk      (clk),
        .resetb   (resetb),
        .apb      (apb),
        .spi_sck  (spi_sck),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso),
        .spi_cs_n (spi_cs_n),
        .spi_oe   (spi_oe),
        .irq      (irq)
    );

    int checks = 0;
    int failures = 0;

    // SCK monitor: records rising-edge times and MOSI values, feeds MISO pattern MSB-first.
    int          cyc = 0;
    bit          mon_en = 0;
    logic        sck_prev = 1'b0;
    int          rise_q[$];
    logic        mosi_q[$];
    int          bit_idx = 0;
    int          cur_n = 1;
    logic [31:0] miso_pat = '0;
    bit          irq_seen = 0;

    always @(negedge clk) begin
        cyc++;
        if (mon_en) begin
            if (spi_sck && !sck_prev) begin
                rise_q.push_back(cyc);
                mosi_q.push_back(spi_mosi);
            end
            if (!spi_sck && sck_prev) begin
                bit_idx++;
                if (bit_idx < cur_n) miso_drv = miso_pat[cur_n-1-bit_idx];
            end
        end
        sck_prev = spi_sck;
        if (irq !== 1'b0) irq_seen = 1;
    end

    task automatic apb_write(input logic [7:0] addr, input logic [31:0] data);
        @(posedge clk); #1;
        apb.paddr = addr; apb.pwdata = data; apb.pwrite = 1'b1; apb.psel = 1'b1; apb.penable = 1'b0;
        @(posedge clk); #1;
        apb.penable = 1'b1;
        @(posedge clk); #1;
        apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [7:0] addr, output logic [31:0] data);
        @(posedge clk); #1;
        apb.paddr = addr; apb.pwrite = 1'b0; apb.psel = 1'b1; apb.penable = 1'b0;
        @(posedge clk); #1;
        apb.penable = 1'b1;
        #1 data = apb.prdata;
        @(posedge clk); #1;
        apb.psel = 1'b0; apb.penable = 1'b0;
    endtask

    // Holds a continuous STATUS read and counts cycles with busy=1; returns at the first not-busy negedge.
    task automatic poll_busy(output int cnt);
        apb.paddr = 8'h08; apb.pwrite = 1'b0; apb.psel = 1'b1; apb.penable = 1'b1;
        cnt = 0;
        while (1) begin
            @(negedge clk);
            if (apb.prdata[0] !== 1'b1) break;
            cnt++;
            if (cnt >= 5000) break;
        end
        apb.psel = 1'b0; apb.penable = 1'b0;
    endtask

    task automatic run_xfer(input logic [31:0] tx, input int n, input int d, input bit lb,
                            input logic [31:0] pat, output int bcnt);
        apb_write(8'h0C, 32'(d));
        apb_write(8'h00, tx);
        rise_q.delete(); mosi_q.delete();
        loopback = lb; miso_pat = pat; cur_n = n; bit_idx = 0; miso_drv = pat[n-1];
        sck_prev = spi_sck; mon_en = 1;
        apb_write(8'h04, 32'(n));
        poll_busy(bcnt);
        mon_en = 0;
    endtask

    function automatic logic [31:0] nmask(input int n);
        logic [63:0] m;
        m = (64'd1 << n) - 64'd1;
        return m[31:0];
    endfunction

    task automatic test_reset();
        logic [31:0] r;
        resetb = 1'b0;
        #12;
        checks++; if (spi_sck !== 1'b0)  begin failures++; $display("FAIL reset_sck got=%b exp=0", spi_sck); end
        checks++; if (spi_mosi !== 1'b1) begin failures++; $display("FAIL reset_mosi got=%b exp=1", spi_mosi); end
        checks++; if (spi_cs_n !== 1'b1) begin failures++; $display("FAIL reset_cs_n got=%b exp=1", spi_cs_n); end
        checks++; if (spi_oe !== 1'b0)   begin failures++; $display("FAIL reset_oe got=%b exp=0", spi_oe); end
        checks++; if (irq !== 1'b0)      begin failures++; $display("FAIL reset_irq got=%b exp=0", irq); end
        @(negedge clk); resetb = 1'b1;
        apb_read(8'h08, r);
        checks++; if (r !== 32'h0) begin failures++; $display("FAIL reset_status got=%h exp=0", r); end
        apb_read(8'h0C, r);
        checks++; if (r !== 32'h7C) begin failures++; $display("FAIL reset_div got=%h exp=7c", r); end
        apb_read(8'h10, r);
        checks++; if (r !== 32'h0) begin failures++; $display("FAIL reset_cs got=%h exp=0", r); end
        apb_read(8'h00, r);
        checks++; if (r !== 32'h0) begin failures++; $display("FAIL reset_rxdata got=%h exp=0", r); end
        apb_read(8'h40, r);
        checks++; if (r !== 32'hFFFFFFFF) begin failures++; $display("FAIL unmapped_40 got=%h exp=ffffffff", r); end
        apb_read(8'h14, r);
`ifdef SD_SPI_IRQ_EN
        checks++; if (r !== 32'h0) begin failures++; $display("FAIL reset_irqen got=%h exp=0", r); end
`else
        checks++; if (r !== 32'hFFFFFFFF) begin failures++; $display("FAIL irqen_absent got=%h exp=ffffffff", r); end
`endif
    endtask

    // Checks one completed transfer against the model derived from tx/n/div/miso source.
    task automatic test_transfer(input string name, input logic [31:0] tx, input int n, input int d,
                                 input bit lb, input logic [31:0] pat);
        int bcnt, bad_mosi, bad_per;
        logic [31:0] r, exp_rx;
        run_xfer(tx, n, d, lb, pat, bcnt);
        exp_rx = (lb ? tx : pat) & nmask(n);
        checks++; if (bcnt != 1 + 2*n*(d+1)) begin failures++; $display("FAIL %s busy_cycles got=%0d exp=%0d", name, bcnt, 1 + 2*n*(d+1)); end
        checks++; if (rise_q.size() != n) begin failures++; $display("FAIL %s sck_pulses got=%0d exp=%0d", name, rise_q.size(), n); end
        bad_mosi = 0; bad_per = 0;
        for (int i = 0; i < rise_q.size() && i < n; i++) begin
            if (mosi_q[i] !== tx[n-1-i]) bad_mosi++;
            if (i > 0 && rise_q[i] - rise_q[i-1] != 2*(d+1)) bad_per++;
        end
        checks++; if (bad_mosi != 0) begin failures++; $display("FAIL %s mosi_bits wrong=%0d exp=0", name, bad_mosi); end
        checks++; if (bad_per != 0) begin failures++; $display("FAIL %s sck_period wrong=%0d exp=0", name, bad_per); end
        apb_read(8'h00, r);
        checks++; if (r !== exp_rx) begin failures++; $display("FAIL %s rxdata got=%h exp=%h", name, r, exp_rx); end
        apb_read(8'h04, r);
        checks++; if (r !== 32'(n)) begin failures++; $display("FAIL %s ctrl_rb got=%0d exp=%0d", name, r, n); end
        apb_read(8'h08, r);
        checks++; if (r !== 32'h2) begin failures++; $display("FAIL %s status_done got=%h exp=2", name, r); end
        checks++; if (spi_mosi !== 1'b1) begin failures++; $display("FAIL %s mosi_idle got=%b exp=1", name, spi_mosi); end
        apb_write(8'h08, 32'h2);
        apb_read(8'h08, r);
        checks++; if (r !== 32'h0) begin failures++; $display("FAIL %s status_w1c got=%h exp=0", name, r); end
    endtask

    task automatic test_basic();
        apb_write(8'h10, 32'h2);
        checks++; if (spi_oe !== 1'b1)   begin failures++; $display("FAIL cs_oe got=%b exp=1", spi_oe); end
        checks++; if (spi_cs_n !== 1'b1) begin failures++; $display("FAIL cs_level got=%b exp=1", spi_cs_n); end
        test_transfer("basic_a5", 32'hA5, 8, 0, 1'b1, 32'h0);
        test_transfer("long_32", 32'hFFFFFFFF, 32, 3, 1'b0, 32'h0);
    endtask

    task automatic test_random();
        int n, d;
        logic [31:0] cs;
        for (int i = 0; i < 6; i++) begin
            n = (i == 0) ? 1 : (i == 1) ? 32 : $urandom_range(32, 1);
            d = $urandom_range(3, 0);
            cs = 32'($urandom_range(3, 0));
            apb_write(8'h10, cs);
            checks++; if (spi_cs_n !== ~cs[0]) begin failures++; $display("FAIL rand_cs_n got=%b exp=%b", spi_cs_n, ~cs[0]); end
            test_transfer($sformatf("rand%0d", i), $urandom, n, d, 1'b0, $urandom);
        end
    endtask

    task automatic test_ignored();
        int bcnt;
        logic [31:0] r;
        apb_write(8'h0C, 32'h1);
        apb_write(8'h00, 32'hC3);
        loopback = 1'b1; mon_en = 0;
        apb_write(8'h04, 32'd8);
        apb_write(8'h00, 32'h12);
        apb_write(8'h04, 32'd4);
        apb_write(8'h0C, 32'd9);
        poll_busy(bcnt);
        checks++; if (bcnt >= 5000) begin failures++; $display("FAIL ign_busy_timeout got=%0d exp<5000", bcnt); end
        apb_read(8'h00, r);
        checks++; if (r !== 32'hC3) begin failures++; $display("FAIL ign_rxdata got=%h exp=c3", r); end
        apb_read(8'h04, r);
        checks++; if (r !== 32'd8) begin failures++; $display("FAIL ign_ctrl got=%0d exp=8", r); end
        apb_read(8'h0C, r);
        checks++; if (r !== 32'h1) begin failures++; $display("FAIL ign_div got=%h exp=1", r); end
        test_transfer("ign_txkept", 32'hC3, 8, 1, 1'b1, 32'h0);
        apb_write(8'h04, 32'd0);
        apb_read(8'h08, r);
        checks++; if (r[0] !== 1'b0) begin failures++; $display("FAIL ctrl0_busy got=%b exp=0", r[0]); end
        apb_write(8'h04, 32'd33);
        apb_read(8'h08, r);
        checks++; if (r[0] !== 1'b0) begin failures++; $display("FAIL ctrl33_busy got=%b exp=0", r[0]); end
        apb_read(8'h04, r);
        checks++; if (r !== 32'd8) begin failures++; $display("FAIL ctrl_invalid_rb got=%0d exp=8", r); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] r;
        apb_write(8'h10, 32'h3);
        apb_write(8'h0C, 32'h2);
        apb_write(8'h00, $urandom);
        loopback = 1'b1;
        apb_write(8'h04, 32'd16);
        repeat (40) @(negedge clk);
        #2 resetb = 1'b0;
        #1;
        checks++; if (spi_sck !== 1'b0)  begin failures++; $display("FAIL midrst_sck got=%b exp=0", spi_sck); end
        checks++; if (spi_cs_n !== 1'b1) begin failures++; $display("FAIL midrst_cs_n got=%b exp=1", spi_cs_n); end
        checks++; if (spi_oe !== 1'b0)   begin failures++; $display("FAIL midrst_oe got=%b exp=0", spi_oe); end
        checks++; if (spi_mosi !== 1'b1) begin failures++; $display("FAIL midrst_mosi got=%b exp=1", spi_mosi); end
        @(negedge clk); resetb = 1'b1;
        apb_read(8'h08, r);
        checks++; if (r !== 32'h0) begin failures++; $display("FAIL midrst_status got=%h exp=0", r); end
        repeat (20) @(posedge clk);
        apb_read(8'h00, r);
        checks++; if (r !== 32'h0) begin failures++; $display("FAIL midrst_rxdata got=%h exp=0", r); end
        apb_read(8'h0C, r);
        checks++; if (r !== 32'h7C) begin failures++; $display("FAIL midrst_div got=%h exp=7c", r); end
    endtask

    task automatic test_irq();
`ifdef SD_SPI_IRQ_EN
        int bcnt;
        logic [31:0] r;
        apb_write(8'h14, 32'h1);
        apb_read(8'h14, r);
        checks++; if (r !== 32'h1) begin failures++; $display("FAIL irqen_rb got=%h exp=1", r); end
        apb_write(8'h0C, 32'h0);
        apb_write(8'h00, 32'h1);
        loopback = 1'b1;
        apb_write(8'h04, 32'd1);
        poll_busy(bcnt);
        checks++; if (bcnt != 3) begin failures++; $display("FAIL irq_busy got=%0d exp=3", bcnt); end
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_early got=%b exp=0", irq); end
        @(negedge clk);
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL irq_rise got=%b exp=1", irq); end
        apb_write(8'h08, 32'h2);
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_w1c got=%b exp=0", irq); end
        apb_read(8'h08, r);
        checks++; if (r !== 32'h0) begin failures++; $display("FAIL irq_status got=%h exp=0", r); end
`else
        checks++; if (irq_seen) begin failures++; $display("FAIL irq_tied got=1 exp=0"); end
`endif
    endtask

    initial begin
        apb.paddr = '0; apb.pwdata = '0; apb.pwrite = 1'b0; apb.psel = 1'b0; apb.penable = 1'b0;
        test_reset();
        test_basic();
        test_random();
        test_ignored();
        test_reset_mid();
        test_irq();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
